noise_test_multi: RTL and testbench



---
 rtl/noise_test_pkg.sv | 30 +++
 rtl/hex_to_7seg.sv | 11 +
 rtl/noise_test_multi.sv | 155 +++++++++++++++
 tb/tb_noise_test_multi.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/noise_test_pkg.sv
// Shared types and constants for the multi-channel noise tester:
// FSM states, LFSR geometry, and active-low 7-segment glyphs.
package noise_test_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int LFSR_W = 16;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Segment order {g,f,e,d,c,b,a}, active-low; index = nibble value
  localparam logic [15:0][6:0] SEG_GLYPH = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational nibble to active-low 7-segment decoder.
module hex_to_7seg
  import noise_test_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_GLYPH[nibble];

endmodule

// File: rtl/noise_test_multi.sv
// Multi-channel PRBS noise tester: drives tx_pin, compares synchronised rx_pin
// once per bit, keeps saturating per-channel error counts shown on HEX0..HEX3.
//
// state  | meaning
// S_IDLE | outputs quiet, waiting for a start edge
// S_RUN  | transmitting N_BITS bits, counting mismatches
// S_DONE | run finished, counts held and valid
module noise_test_multi
  import noise_test_pkg::*;
#(
  parameter int              N_CH          = 2,
  parameter int              BIT_PERIOD    = 50,
  parameter int              SAMPLE_OFFSET = 40,
  parameter int              N_BITS        = 1000,
  parameter int              CNT_W         = 16,
  parameter logic [15:0]     SEED          = 16'hACE1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [3:0]      chan_sel,
  input  logic [N_CH-1:0] rx_pin,
  output logic [N_CH-1:0] tx_pin,
  output logic            busy,
  output logic            done,
  output logic [6:0]      HEX0,
  output logic [6:0]      HEX1,
  output logic [6:0]      HEX2,
  output logic [6:0]      HEX3
);

  localparam int PH_W = $clog2(BIT_PERIOD);
  localparam int BC_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  state_t                      state, state_next;
  logic [2:0]                  start_sync;
  logic                        start_pulse;
  logic [N_CH-1:0]             rx_meta, rx_sync;
  logic [LFSR_W-1:0]           lfsr, lfsr_adv;
  logic [PH_W-1:0]             phase;
  logic [BC_W-1:0]             bit_cnt;
  logic [N_CH-1:0][CNT_W-1:0]  err_cnt;
  logic                        launch, sample_now, bit_end, last_bit;
  logic [15:0]                 cnt_sel;
  logic [3:0][6:0]             seg_next;

  // Edge pulse is registered so a run begins three edges after start is seen
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_sync  <= '0;
      start_pulse <= 1'b0;
      rx_meta     <= '0;
      rx_sync     <= '0;
    end else begin
      start_sync  <= {start_sync[1:0], start};
      start_pulse <= start_sync[1] & ~start_sync[2];
      rx_meta     <= rx_pin;
      rx_sync     <= rx_meta;
    end
  end

  assign launch     = (state != S_RUN) && start_pulse;
  assign sample_now = (state == S_RUN) && (phase == PH_W'(SAMPLE_OFFSET));
  assign bit_end    = (state == S_RUN) && (phase == PH_W'(BIT_PERIOD - 1));
  assign last_bit   = (bit_cnt == BC_W'(N_BITS - 1));
  assign lfsr_adv   = lfsr_next(lfsr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: if (start_pulse) state_next = S_RUN;
      S_RUN:          if (bit_end && last_bit) state_next = S_DONE;
      default:        state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr    <= '0;
      tx_pin  <= '0;
      phase   <= '0;
      bit_cnt <= '0;
    end else if (launch) begin
      lfsr    <= SEED;
      tx_pin  <= SEED[N_CH-1:0];
      phase   <= '0;
      bit_cnt <= '0;
    end else if (state == S_RUN) begin
      if (bit_end) begin
        phase <= '0;
        if (last_bit) begin
          tx_pin <= '0;
        end else begin
          lfsr    <= lfsr_adv;
          tx_pin  <= lfsr_adv[N_CH-1:0];
          bit_cnt <= bit_cnt + BC_W'(1);
        end
      end else begin
        phase <= phase + PH_W'(1);
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        cnt <= '0;
      else if (launch)
        cnt <= '0;
      else if (sample_now && (rx_sync[i] != tx_pin[i]) && (cnt != '1))
        cnt <= cnt + CNT_W'(1);
    end
    assign err_cnt[i] = cnt;
  end

  // Out-of-range selections fall through to zero
  always_comb begin
    cnt_sel = '0;
    for (int i = 0; i < N_CH; i++)
      if (chan_sel == 4'(i)) cnt_sel = 16'(err_cnt[i]);
  end

  for (genvar d = 0; d < 4; d++) begin : g_hex
    hex_to_7seg u_dec (
      .nibble(cnt_sel[4*d +: 4]),
      .seg   (seg_next[d])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      HEX0 <= SEG_ZERO;
      HEX1 <= SEG_ZERO;
      HEX2 <= SEG_ZERO;
      HEX3 <= SEG_ZERO;
    end else begin
      HEX0 <= seg_next[0];
      HEX1 <= seg_next[1];
      HEX2 <= seg_next[2];
      HEX3 <= seg_next[3];
    end
  end

endmodule

// File: tb/tb_noise_test_multi.sv
// Directed bench for noise_test_multi: three parameter sets, table-driven runs
// plus hand-written reset and default-size sequences.
module tb_noise_test_multi;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] chan_sel = 4'd0;
  int         which = 0;
  logic [1:0] inv_a = 2'b00;

  always #10 clk = ~clk;

  logic       start_a, start_b, start_d;
  logic [1:0] rx_a, rx_b, rx_d, tx_a, tx_b, tx_d;
  logic       busy_a, busy_b, busy_d, done_a, done_b, done_d;
  logic [6:0] h0_a, h1_a, h2_a, h3_a, h0_b, h1_b, h2_b, h3_b, h0_d, h1_d, h2_d, h3_d;

  assign start_a = start && (which == 0);
  assign start_b = start && (which == 1);
  assign start_d = start && (which == 2);
  assign rx_a = tx_a ^ inv_a;
  assign rx_b = ~tx_b;
  assign rx_d = ~tx_d;

  noise_test_multi #(.N_CH(2), .BIT_PERIOD(8), .SAMPLE_OFFSET(6), .N_BITS(20), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .chan_sel(chan_sel), .rx_pin(rx_a),
    .tx_pin(tx_a), .busy(busy_a), .done(done_a),
    .HEX0(h0_a), .HEX1(h1_a), .HEX2(h2_a), .HEX3(h3_a));

  noise_test_multi #(.N_CH(2), .BIT_PERIOD(8), .SAMPLE_OFFSET(6), .N_BITS(20), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .chan_sel(chan_sel), .rx_pin(rx_b),
    .tx_pin(tx_b), .busy(busy_b), .done(done_b),
    .HEX0(h0_b), .HEX1(h1_b), .HEX2(h2_b), .HEX3(h3_b));

  noise_test_multi dut_d (
    .clk(clk), .reset(reset), .start(start_d), .chan_sel(chan_sel), .rx_pin(rx_d),
    .tx_pin(tx_d), .busy(busy_d), .done(done_d),
    .HEX0(h0_d), .HEX1(h1_d), .HEX2(h2_d), .HEX3(h3_d));

  logic        busy_m, done_m;
  logic [1:0]  tx_m;
  logic [27:0] hex_m;

  always_comb begin
    case (which)
      0:       begin busy_m = busy_a; done_m = done_a; tx_m = tx_a; hex_m = {h3_a, h2_a, h1_a, h0_a}; end
      1:       begin busy_m = busy_b; done_m = done_b; tx_m = tx_b; hex_m = {h3_b, h2_b, h1_b, h0_b}; end
      default: begin busy_m = busy_d; done_m = done_d; tx_m = tx_d; hex_m = {h3_d, h2_d, h1_d, h0_d}; end
    endcase
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [27:0] exp_hex(input logic [15:0] c);
    return {glyph(c[15:12]), glyph(c[11:8]), glyph(c[7:4]), glyph(c[3:0])};
  endfunction

  // Pulses start, checks launch latency, then follows busy while checking tx
  // against an independent LFSR model. extra>0 fires a second start mid-run.
  task automatic do_run(input string tag, input int bp, input int nb, input int extra);
    logic [15:0] l;
    int len, ph, tx_err;
    l = 16'hACE1;
    len = 0; ph = 0; tx_err = 0;
    @(negedge clk); start = 1'b1;
    repeat (3) @(negedge clk);
    check({tag, "_lat_e2"}, 32'(busy_m), 32'd0);
    start = 1'b0;
    @(negedge clk);
    check({tag, "_lat_e3"}, 32'(busy_m), 32'd1);
    while (busy_m && len < 60000) begin
      if (tx_m !== l[1:0]) tx_err++;
      len++; ph++;
      if (ph == bp) begin
        ph = 0;
        l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      end
      if (len == extra) start = 1'b1;
      if (len == extra + 3) start = 1'b0;
      @(negedge clk);
    end
    check({tag, "_busy_len"}, 32'(len), 32'(nb * bp));
    check({tag, "_tx_seq_errs"}, 32'(tx_err), 32'd0);
    check({tag, "_done"}, 32'(done_m), 32'd1);
    check({tag, "_tx_idle"}, 32'(tx_m), 32'd0);
  endtask

  typedef struct {
    int         which;
    logic [1:0] inv;
    logic [3:0] sel;
    logic [15:0] cnt;
    int         extra;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  initial begin
    vecs[0]  = '{0, 2'b00, 4'd0,  16'd0,  -10};
    vecs[1]  = '{0, 2'b00, 4'd1,  16'd0,  -10};
    vecs[2]  = '{0, 2'b11, 4'd0,  16'd20, -10};
    vecs[3]  = '{0, 2'b11, 4'd1,  16'd20, 40};
    vecs[4]  = '{0, 2'b10, 4'd0,  16'd0,  -10};
    vecs[5]  = '{0, 2'b10, 4'd1,  16'd20, -10};
    vecs[6]  = '{0, 2'b10, 4'd5,  16'd0,  -10};
    vecs[7]  = '{0, 2'b01, 4'd0,  16'd20, 100};
    vecs[8]  = '{0, 2'b01, 4'd1,  16'd0,  -10};
    vecs[9]  = '{0, 2'b01, 4'd15, 16'd0,  -10};
    vecs[10] = '{1, 2'b11, 4'd0,  16'd15, -10};
    vecs[11] = '{1, 2'b11, 4'd1,  16'd15, -10};

    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_hex", 32'({h3_a, h2_a, h1_a, h0_a}), 32'(exp_hex(16'h0000)));
    check("rst_hex_d", 32'({h3_d, h2_d, h1_d, h0_d}), 32'(exp_hex(16'h0000)));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < NV; k++) begin
      which = vecs[k].which;
      inv_a = vecs[k].inv;
      chan_sel = 4'd0;
      do_run($sformatf("v%0d", k), 8, 20, vecs[k].extra);
      chan_sel = vecs[k].sel;
      repeat (2) @(negedge clk);
      check($sformatf("v%0d_hex", k), 32'(hex_m), 32'(exp_hex(vecs[k].cnt)));
    end

    // Asynchronous reset in the middle of an inverted run
    which = 0; inv_a = 2'b11; chan_sel = 4'd0;
    @(negedge clk); start = 1'b1;
    repeat (4) @(negedge clk); start = 1'b0;
    repeat (60) @(negedge clk);
    check("pre_rst_busy", 32'(busy_a), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_tx", 32'(tx_a), 32'd0);
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    check("mid_rst_done", 32'(done_a), 32'd0);
    check("mid_rst_hex", 32'({h3_a, h2_a, h1_a, h0_a}), 32'(exp_hex(16'h0000)));
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_hex", 32'(hex_m), 32'(exp_hex(16'h0000)));
    do_run("rerun", 8, 20, -10);
    repeat (2) @(negedge clk);
    check("rerun_hex", 32'(hex_m), 32'(exp_hex(16'd20)));

    // Default-size run: 1000 bits x 50 clocks, both channels inverted
    which = 2; chan_sel = 4'd1;
    do_run("dflt", 50, 1000, -10);
    repeat (2) @(negedge clk);
    check("dflt_hex_ch1", 32'(hex_m), 32'(exp_hex(16'h03E8)));
    chan_sel = 4'd0;
    repeat (2) @(negedge clk);
    check("dflt_hex_ch0", 32'(hex_m), 32'(exp_hex(16'h03E8)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
